// File: rtl/envelope_adsr.sv
// envelope_adsr: per-voice ADSR envelope generator; all state advances on sample_tick.
// Build macro ENVELOPE_ADSR_LINEAR_EN adds a 'linear' input that forces unit-size steps.

module envelope_adsr #(
    parameter int VOL_W         = 8,
    parameter int RATE_W        = 8,
    parameter int ATTACK_SHIFT  = 6,
    parameter int DECAY_SHIFT   = 5,
    parameter int RELEASE_SHIFT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              gate,
    input  logic [RATE_W-1:0] a,
    input  logic [RATE_W-1:0] d,
    input  logic [VOL_W-1:0]  s,
    input  logic [RATE_W-1:0] r,
`ifdef ENVELOPE_ADSR_LINEAR_EN
    input  logic              linear,
`endif
    output logic [VOL_W-1:0]  volume,
    output logic [2:0]        state,
    output logic              busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [VOL_W-1:0]  VMAX    = {VOL_W{1'b1}};
    localparam logic [VOL_W-1:0]  ZERO_V  = {VOL_W{1'b0}};
    localparam logic [VOL_W-1:0]  ONE_V   = {{(VOL_W-1){1'b0}}, 1'b1};
    localparam logic [RATE_W:0]   ATT_ZERO = {(RATE_W+1){1'b0}};
    localparam logic [RATE_W+1:0] DR_ZERO  = {(RATE_W+2){1'b0}};

    // Every step moves the envelope by at least one LSB so each stage terminates.
    function automatic logic [VOL_W-1:0] step_size(input logic [VOL_W-1:0] raw,
                                                   input logic lin);
        logic [VOL_W-1:0] res;
        if (lin) begin
            res = ONE_V;
        end else if (raw == ZERO_V) begin
            res = ONE_V;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        next_state_s;
    logic [VOL_W-1:0]  volume_r;
    logic [VOL_W-1:0]  vol_next_s;
    logic [RATE_W:0]   att_acc_r;
    logic [RATE_W:0]   att_acc_next_s;
    logic [RATE_W+1:0] dr_acc_r;
    logic [RATE_W+1:0] dr_acc_next_s;
    logic              busy_r;
    logic              lin_s;

    logic [RATE_W+1:0] att_sum_s;
    logic              att_carry_s;
    logic [RATE_W-1:0] dr_rate_s;
    logic [RATE_W+2:0] dr_sum_s;
    logic              dr_carry_s;

    logic [VOL_W-1:0]  att_step_s;
    logic [VOL_W:0]    att_total_s;
    logic [VOL_W-1:0]  att_vol_s;
    logic [VOL_W-1:0]  dec_gap_s;
    logic [VOL_W-1:0]  dec_step_s;
    logic [VOL_W-1:0]  dec_vol_s;
    logic [VOL_W-1:0]  rel_step_s;
    logic [VOL_W-1:0]  rel_vol_s;

`ifdef ENVELOPE_ADSR_LINEAR_EN
    assign lin_s = linear;
`else
    assign lin_s = 1'b0;
`endif

    // Phase accumulators: a step fires when the sum carries out of the accumulator width.
    assign att_sum_s   = {1'b0, att_acc_r} + {2'b00, a};
    assign att_carry_s = att_sum_s[RATE_W+1];
    assign dr_rate_s   = (state_r == ST_DECAY) ? d : r;
    assign dr_sum_s    = {1'b0, dr_acc_r} + {3'b000, dr_rate_s};
    assign dr_carry_s  = dr_sum_s[RATE_W+2];

    assign att_step_s  = step_size((VMAX - volume_r) >> ATTACK_SHIFT, lin_s);
    assign att_total_s = {1'b0, volume_r} + {1'b0, att_step_s};
    assign att_vol_s   = (att_total_s > {1'b0, VMAX}) ? VMAX : att_total_s[VOL_W-1:0];

    // The decay gap is only consumed while volume is above the sustain level.
    assign dec_gap_s   = volume_r - s;
    assign dec_step_s  = step_size(dec_gap_s >> DECAY_SHIFT, lin_s);
    assign dec_vol_s   = (dec_step_s >= dec_gap_s) ? s : (volume_r - dec_step_s);

    assign rel_step_s  = step_size(volume_r >> RELEASE_SHIFT, lin_s);
    assign rel_vol_s   = (rel_step_s >= volume_r) ? ZERO_V : (volume_r - rel_step_s);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            volume_r  <= ZERO_V;
            att_acc_r <= ATT_ZERO;
            dr_acc_r  <= DR_ZERO;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            volume_r  <= vol_next_s;
            att_acc_r <= att_acc_next_s;
            dr_acc_r  <= dr_acc_next_s;
            busy_r    <= (next_state_s != ST_IDLE);
        end
    end

    // Next-state selection, first matching rule per state wins.
    always_comb begin
        next_state_s = state_r;
        if (sample_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (gate) begin
                        next_state_s = ST_ATTACK;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        next_state_s = ST_RELEASE;
                    end else if (volume_r == VMAX) begin
                        next_state_s = ST_DECAY;
                    end else begin
                        next_state_s = ST_ATTACK;
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        next_state_s = ST_RELEASE;
                    end else if (volume_r <= s) begin
                        next_state_s = ST_SUSTAIN;
                    end else begin
                        next_state_s = ST_DECAY;
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        next_state_s = ST_RELEASE;
                    end else begin
                        next_state_s = ST_SUSTAIN;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        next_state_s = ST_ATTACK;
                    end else if (volume_r == ZERO_V) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_RELEASE;
                    end
                end
                default: next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Volume and accumulator updates; transition ticks only clear accumulators.
    always_comb begin
        vol_next_s     = volume_r;
        att_acc_next_s = att_acc_r;
        dr_acc_next_s  = dr_acc_r;
        if (sample_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (gate) begin
                        att_acc_next_s = ATT_ZERO;
                    end else begin
                        vol_next_s = volume_r;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        dr_acc_next_s = DR_ZERO;
                    end else if (volume_r == VMAX) begin
                        dr_acc_next_s = DR_ZERO;
                    end else begin
                        att_acc_next_s = att_sum_s[RATE_W:0];
                        if (att_carry_s) begin
                            vol_next_s = att_vol_s;
                        end else begin
                            vol_next_s = volume_r;
                        end
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        dr_acc_next_s = DR_ZERO;
                    end else if (volume_r <= s) begin
                        vol_next_s = volume_r;
                    end else begin
                        dr_acc_next_s = dr_sum_s[RATE_W+1:0];
                        if (dr_carry_s) begin
                            vol_next_s = dec_vol_s;
                        end else begin
                            vol_next_s = volume_r;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        dr_acc_next_s = DR_ZERO;
                    end else begin
                        vol_next_s = s;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        att_acc_next_s = ATT_ZERO;
                    end else if (volume_r == ZERO_V) begin
                        vol_next_s = volume_r;
                    end else begin
                        dr_acc_next_s = dr_sum_s[RATE_W+1:0];
                        if (dr_carry_s) begin
                            vol_next_s = rel_vol_s;
                        end else begin
                            vol_next_s = volume_r;
                        end
                    end
                end
                default: begin
                    vol_next_s     = ZERO_V;
                    att_acc_next_s = ATT_ZERO;
                    dr_acc_next_s  = DR_ZERO;
                end
            endcase
        end else begin
            vol_next_s = volume_r;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        volume = volume_r;
        state  = state_r;
        busy   = busy_r;
    end

endmodule

// File: tb/tb_envelope_adsr.sv
// Directed self-checking bench for envelope_adsr (default parameters, exponential build).
`timescale 1ns/1ps

module tb_envelope_adsr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic       gate = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] d = 8'd0;
    logic [7:0] s = 8'd0;
    logic [7:0] r = 8'd0;
`ifdef ENVELOPE_ADSR_LINEAR_EN
    logic       linear = 1'b0;
`endif
    logic [7:0] volume;
    logic [2:0] state;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    envelope_adsr dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .gate(gate),
        .a(a), .d(d), .s(s), .r(r),
`ifdef ENVELOPE_ADSR_LINEAR_EN
        .linear(linear),
`endif
        .volume(volume), .state(state), .busy(busy)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(posedge clk);
            #1;
            sample_tick = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        gate = 1'b1; a = 8'd255;
        pulse_reset();
        gate = 1'b0;
        n_vec++; if (volume !== 8'd0) begin n_err++; $display("FAIL rst_volume got %0d expected 0", volume); end
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d expected 0", state); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0d expected 0", busy); end
    endtask

    task automatic test_attack_start();
        gate = 1'b1; a = 8'd255; d = 8'd255; s = 8'd128; r = 8'd255;
        tick(1);
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL att_enter_state got %0d expected 1", state); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL att_busy got %0d expected 1", busy); end
        n_vec++; if (volume !== 8'd0) begin n_err++; $display("FAIL att_enter_vol got %0d expected 0", volume); end
        tick(2);
        n_vec++; if (volume !== 8'd0) begin n_err++; $display("FAIL att_acc_nocarry got %0d expected 0", volume); end
        tick(1);
        n_vec++; if (volume !== 8'd3) begin n_err++; $display("FAIL att_first_step got %0d expected 3", volume); end
        tick(2);
        n_vec++; if (volume !== 8'd6) begin n_err++; $display("FAIL att_second_step got %0d expected 6", volume); end
    endtask

    task automatic test_decay();
        for (int i = 0; i < 4000 && volume !== 8'd255; i++) tick(1);
        n_vec++; if (volume !== 8'd255) begin n_err++; $display("FAIL att_peak got %0d expected 255", volume); end
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL att_peak_state got %0d expected 1", state); end
        tick(1);
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL dec_enter got %0d expected 2", state); end
        tick(4);
        n_vec++; if (volume !== 8'd255) begin n_err++; $display("FAIL dec_nocarry got %0d expected 255", volume); end
        tick(1);
        n_vec++; if (volume !== 8'd252) begin n_err++; $display("FAIL dec_first_step got %0d expected 252", volume); end
        for (int i = 0; i < 4000 && state !== 3'd3; i++) tick(1);
        n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL sus_enter got %0d expected 3", state); end
        n_vec++; if (volume !== 8'd128) begin n_err++; $display("FAIL sus_level got %0d expected 128", volume); end
        s = 8'd100;
        tick(1);
        n_vec++; if (volume !== 8'd100) begin n_err++; $display("FAIL sus_track got %0d expected 100", volume); end
    endtask

    task automatic test_retrigger();
        gate = 1'b0; r = 8'd0;
        tick(1);
        n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL rel_enter got %0d expected 4", state); end
        tick(10);
        n_vec++; if (volume !== 8'd100) begin n_err++; $display("FAIL rel_rate0 got %0d expected 100", volume); end
        gate = 1'b1; a = 8'd255;
        tick(1);
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL retrig_state got %0d expected 1", state); end
        n_vec++; if (volume !== 8'd100) begin n_err++; $display("FAIL retrig_vol got %0d expected 100", volume); end
        tick(3);
        n_vec++; if (volume !== 8'd102) begin n_err++; $display("FAIL retrig_step got %0d expected 102", volume); end
    endtask

    task automatic test_rate_zero();
        d = 8'd255; s = 8'd40;
        for (int i = 0; i < 8000 && state !== 3'd3; i++) tick(1);
        n_vec++; if (volume !== 8'd40) begin n_err++; $display("FAIL sus40 got %0d expected 40", volume); end
        gate = 1'b0; r = 8'd0;
        tick(1);
        gate = 1'b1; a = 8'd0;
        tick(1);
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL a0_state got %0d expected 1", state); end
        tick(1000);
        n_vec++; if (volume !== 8'd40) begin n_err++; $display("FAIL a0_hold got %0d expected 40", volume); end
        gate = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL notick_state got %0d expected 1", state); end
        n_vec++; if (volume !== 8'd40) begin n_err++; $display("FAIL notick_vol got %0d expected 40", volume); end
        gate = 1'b1;
    endtask

    task automatic test_sustain_max_release();
        a = 8'd255; d = 8'd255; s = 8'd255;
        for (int i = 0; i < 4000 && state !== 3'd2; i++) tick(1);
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL smax_decay got %0d expected 2", state); end
        tick(1);
        n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL smax_sustain got %0d expected 3", state); end
        n_vec++; if (volume !== 8'd255) begin n_err++; $display("FAIL smax_vol got %0d expected 255", volume); end
        gate = 1'b0; r = 8'd255;
        tick(1);
        n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL rel_state got %0d expected 4", state); end
        tick(4);
        n_vec++; if (volume !== 8'd255) begin n_err++; $display("FAIL rel_nocarry got %0d expected 255", volume); end
        tick(1);
        n_vec++; if (volume !== 8'd248) begin n_err++; $display("FAIL rel_first_step got %0d expected 248", volume); end
        for (int i = 0; i < 8000 && volume !== 8'd0; i++) tick(1);
        n_vec++; if (volume !== 8'd0) begin n_err++; $display("FAIL rel_floor got %0d expected 0", volume); end
        n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL rel_floor_state got %0d expected 4", state); end
        tick(1);
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_state got %0d expected 0", state); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %0d expected 0", busy); end
    endtask

    task automatic test_reset_mid_decay();
        gate = 1'b1; a = 8'd255; d = 8'd255; s = 8'd0;
        for (int i = 0; i < 4000 && state !== 3'd2; i++) tick(1);
        for (int i = 0; i < 4000 && volume >= 8'd230; i++) tick(1);
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL mid_decay_state got %0d expected 2", state); end
        pulse_reset();
        n_vec++; if (volume !== 8'd0) begin n_err++; $display("FAIL mid_rst_vol got %0d expected 0", volume); end
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL mid_rst_state got %0d expected 0", state); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %0d expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_attack_start();
        test_decay();
        test_retrigger();
        test_rate_zero();
        test_sustain_max_release();
        test_reset_mid_decay();
        test_attack_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
